// File: rtl/sram_ctrl_param.sv
// ---------------------------------------------------------------------------
// sram_ctrl_param
//
// Bridges the MEM stage to an external asynchronous SRAM. A DATA_W-wide load
// or store is split into DATA_W/SRAM_DW consecutive SRAM beats. Each beat
// lasts WAIT_CYCLES+1 clocks: the strobe phase, then one hold cycle with
// write enable released. freeze_signal stalls the pipeline until the
// one-cycle ready pulse. Out-of-window or misaligned addresses never reach
// the SRAM; they complete right away with addr_err set.
//
// State table:
//   S_IDLE   | waiting for a request; latches and range-checks it
//   S_ACCESS | driving SRAM beats; beat_q / wait_q track position
//   S_DONE   | ready pulse; addr_err reports the latched check result
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   mem_w_en        store request (wins when both enables are high)
//   mem_r_en        load request
//   mem_addr        CPU byte address
//   mem_wdata       store data
//   mem_be          store byte enables, bit i = byte i
//   mem_rdata       registered load data
//   ready           one-cycle completion pulse
//   freeze_signal   stall request to the other pipeline stages
//   addr_err        error flag, valid while ready=1
//   SRAM_DQ         bidirectional SRAM data bus
//   SRAM_ADDR       SRAM word address
//   SRAM_BE_N       active-low byte lane mask
//   SRAM_WE_N       active-low write enable
//   SRAM_CE_N       active-low chip enable
//   SRAM_OE_N       active-low output enable
// ---------------------------------------------------------------------------
module sram_ctrl_param #(
    parameter int          DATA_W      = 32,
    parameter int          SRAM_DW     = 16,
    parameter int          SRAM_AW     = 18,
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_w_en,
    input  logic                   mem_r_en,
    input  logic [31:0]            mem_addr,
    input  logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W/8-1:0]    mem_be,
    output logic [DATA_W-1:0]      mem_rdata,
    output logic                   ready,
    output logic                   freeze_signal,
    output logic                   addr_err,
    inout  wire  [SRAM_DW-1:0]     SRAM_DQ,
    output logic [SRAM_AW-1:0]     SRAM_ADDR,
    output logic [SRAM_DW/8-1:0]   SRAM_BE_N,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_OE_N
);

    localparam int BEATS   = DATA_W / SRAM_DW;
    localparam int LANES   = SRAM_DW / 8;
    localparam int BYTES   = DATA_W / 8;
    localparam int BEAT_CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WAIT_CW = $clog2(WAIT_CYCLES + 1);

    // Size of the SRAM in CPU bytes; kept 64-bit so SRAM_AW up to 32 works.
    localparam logic [63:0] WINDOW = 64'(LANES) << SRAM_AW;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [BEAT_CW-1:0]   beat_q;
    logic [WAIT_CW-1:0]   wait_q;
    logic                 is_wr_q;
    logic                 err_q;
    logic [SRAM_AW-1:0]   word_q;
    logic [DATA_W-1:0]    wdata_q;
    logic [BYTES-1:0]     be_q;
    logic [DATA_W-1:0]    rdata_q;

    logic                 req;
    logic [31:0]          offset;
    logic                 addr_bad;
    logic                 beat_last;
    logic                 xfer_last;
    logic                 dq_oe;
    logic [SRAM_DW-1:0]   dq_out;

    assign req    = mem_w_en | mem_r_en;
    assign offset = mem_addr - BASE_ADDR;

    // Below-base addresses wrap offset to a huge value, but they are flagged
    // explicitly so the check does not depend on that wrap.
    assign addr_bad = (mem_addr < BASE_ADDR)
                    | ({32'd0, offset} >= WINDOW)
                    | ((offset % 32'(BYTES)) != 32'd0);

    assign beat_last = (wait_q == WAIT_CW'(WAIT_CYCLES));
    assign xfer_last = beat_last & (beat_q == BEAT_CW'(BEATS - 1));

    // -----------------------------------------------------------------------
    // State register and datapath
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            wait_q  <= '0;
            is_wr_q <= 1'b0;
            err_q   <= 1'b0;
            word_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        is_wr_q <= mem_w_en;
                        err_q   <= addr_bad;
                        word_q  <= SRAM_AW'(offset / 32'(LANES));
                        wdata_q <= mem_wdata;
                        be_q    <= mem_be;
                        beat_q  <= '0;
                        wait_q  <= '0;
                        // A rejected load returns zero; a rejected store
                        // leaves the previous load data alone.
                        if (addr_bad && !mem_w_en) begin
                            rdata_q <= '0;
                        end
                    end
                end
                S_ACCESS: begin
                    if (beat_last) begin
                        wait_q <= '0;
                        beat_q <= beat_q + BEAT_CW'(1);
                        if (!is_wr_q) begin
                            for (int i = 0; i < BEATS; i++) begin
                                if (beat_q == BEAT_CW'(i)) begin
                                    rdata_q[i*SRAM_DW +: SRAM_DW] <= SRAM_DQ;
                                end
                            end
                        end
                    end else begin
                        wait_q <= wait_q + WAIT_CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = addr_bad ? S_DONE : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (xfer_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Enables still high here belong to the finishing request.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode. Everything is decoded from flops only, so the strobes
    // change once per clock and settle well before the SRAM samples them.
    // -----------------------------------------------------------------------
    always_comb begin
        SRAM_CE_N = 1'b1;
        SRAM_WE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        SRAM_BE_N = '1;
        SRAM_ADDR = '0;
        dq_oe     = 1'b0;
        dq_out    = '0;
        ready     = 1'b0;
        addr_err  = 1'b0;
        case (state_q)
            S_ACCESS: begin
                SRAM_CE_N = 1'b0;
                // Wraps modulo the SRAM size; the range check keeps valid
                // requests from ever reaching the wrap.
                SRAM_ADDR = word_q + SRAM_AW'(beat_q);
                if (is_wr_q) begin
                    dq_oe = 1'b1;
                    for (int i = 0; i < BEATS; i++) begin
                        if (beat_q == BEAT_CW'(i)) begin
                            dq_out    = wdata_q[i*SRAM_DW +: SRAM_DW];
                            SRAM_BE_N = ~be_q[i*LANES +: LANES];
                        end
                    end
                    // Released on the last cycle of the beat so data and
                    // address are held past the rising edge of WE_N.
                    SRAM_WE_N = beat_last;
                end else begin
                    SRAM_OE_N = 1'b0;
                    SRAM_BE_N = '0;
                end
            end
            S_DONE: begin
                ready    = 1'b1;
                addr_err = err_q;
            end
            default: begin
            end
        endcase
    end

    assign SRAM_DQ       = dq_oe ? dq_out : {SRAM_DW{1'bz}};
    assign mem_rdata     = rdata_q;
    assign freeze_signal = req & ~ready;

endmodule
